// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit framer: header layout, FSM states
// and the UDP length helper.
package udp_pkg;

    localparam int UDP_HDR_LEN = 8;

    localparam logic [2:0] HDR_SRC_HI  = 3'd0;
    localparam logic [2:0] HDR_SRC_LO  = 3'd1;
    localparam logic [2:0] HDR_DST_HI  = 3'd2;
    localparam logic [2:0] HDR_DST_LO  = 3'd3;
    localparam logic [2:0] HDR_LEN_HI  = 3'd4;
    localparam logic [2:0] HDR_LEN_LO  = 3'd5;
    localparam logic [2:0] HDR_CSUM_HI = 3'd6;
    localparam logic [2:0] HDR_CSUM_LO = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_DROP    = 3'd2,
        ST_HDR     = 3'd3,
        ST_PAYLOAD = 3'd4
    } udp_state_t;

    // UDP length field: payload bytes plus header, wrapping modulo 2^16.
    function automatic logic [15:0] udp_len(input logic [15:0] payload_len);
        return payload_len + 16'(UDP_HDR_LEN);
    endfunction

endpackage

// File: rtl/udp_xmit_buf.sv
// Single-clock show-ahead byte FIFO. The read word is re-fetched from RAM every
// cycle, so a freshly written byte becomes visible one cycle after its write.
module udp_xmit_buf
    import udp_pkg::*;
#(
    parameter int BUF_AW = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_flush,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic       i_rd_en,
    output logic [7:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int                DEPTH    = 1 << BUF_AW;
    localparam logic [BUF_AW-1:0] PTR_ONE  = BUF_AW'(1);
    localparam logic [BUF_AW:0]   LVL_ONE  = {{BUF_AW{1'b0}}, 1'b1};
    localparam logic [BUF_AW:0]   LVL_FULL = {1'b1, {BUF_AW{1'b0}}};

    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        r_rd_data;
    logic [BUF_AW-1:0] r_wr_ptr;
    logic [BUF_AW-1:0] r_rd_ptr;
    logic [BUF_AW:0]   r_level;

    logic              w_wr;
    logic              w_rd;
    logic [BUF_AW-1:0] w_rd_addr;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    // Look one entry ahead on a pop so the next word is ready the following cycle.
    assign w_rd_addr = w_rd ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign o_rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/udp_xmit.sv
// UDP transmit framer: buffers one whole payload frame, then emits the 8-byte
// UDP header (checksum 0) followed by the buffered payload.
module udp_xmit
    import udp_pkg::*;
#(
    parameter int BUF_AW = 11
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  udpdata_tdata_in,
    input  logic        udpdata_tvalid_in,
    input  logic        udpdata_tlast_in,
    output logic        udpdata_tready_out,
    input  logic [15:0] src_port_in,
    input  logic [15:0] dest_port_in,
    output logic [7:0]  udp_axis_tdata_out,
    output logic        udp_axis_tvalid_out,
    output logic        udp_axis_tlast_out,
    input  logic        udp_axis_tready_in,
    output logic [15:0] udp_length_out,
    output logic        busy_out,
    output logic        drop_out
);

    localparam logic [BUF_AW:0] CNT_ONE = {{BUF_AW{1'b0}}, 1'b1};

    udp_state_t      r_state;
    logic [2:0]      r_hdr_idx;
    logic [BUF_AW:0] r_count;
    logic [15:0]     r_length;
    logic [15:0]     r_src;
    logic [15:0]     r_dst;
    logic            r_tready;
    logic            r_drop;

    logic            w_in_hs;
    logic            w_out_hs;
    logic            w_tvalid;
    logic            w_last_byte;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_flush;
    logic            w_buf_full;
    logic            w_buf_empty;
    logic [7:0]      w_buf_data;
    logic [7:0]      w_hdr_byte;
    logic [7:0]      w_tdata;
    logic [BUF_AW:0] w_count_inc;
    logic [15:0]     w_len_next;

    assign w_in_hs     = udpdata_tvalid_in && r_tready;
    assign w_tvalid    = (r_state == ST_HDR) || ((r_state == ST_PAYLOAD) && !w_buf_empty);
    assign w_out_hs    = w_tvalid && udp_axis_tready_in;
    assign w_last_byte = (r_state == ST_PAYLOAD) && (r_count == CNT_ONE);
    assign w_count_inc = r_count + CNT_ONE;
    assign w_len_next  = udp_len(16'(w_count_inc));

    assign w_wr_en = w_in_hs && ((r_state == ST_IDLE) || ((r_state == ST_FILL) && !w_buf_full));
    assign w_rd_en = (r_state == ST_PAYLOAD) && w_out_hs;
    // Overflow and end-of-datagram both return the buffer to address 0.
    assign w_flush = ((r_state == ST_FILL) && w_in_hs && w_buf_full) || (w_rd_en && w_last_byte);

    udp_xmit_buf #(
        .BUF_AW (BUF_AW)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr_en),
        .i_wr_data (udpdata_tdata_in),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_buf_data),
        .o_full    (w_buf_full),
        .o_empty   (w_buf_empty)
    );

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_hdr_idx)
            HDR_SRC_HI:  w_hdr_byte = r_src[15:8];
            HDR_SRC_LO:  w_hdr_byte = r_src[7:0];
            HDR_DST_HI:  w_hdr_byte = r_dst[15:8];
            HDR_DST_LO:  w_hdr_byte = r_dst[7:0];
            HDR_LEN_HI:  w_hdr_byte = r_length[15:8];
            HDR_LEN_LO:  w_hdr_byte = r_length[7:0];
            HDR_CSUM_HI: w_hdr_byte = 8'h00;
            HDR_CSUM_LO: w_hdr_byte = 8'h00;
            default:     w_hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_tdata = 8'h00;
        if (r_state == ST_HDR) begin
            w_tdata = w_hdr_byte;
        end else if (r_state == ST_PAYLOAD) begin
            w_tdata = w_buf_data;
        end
    end

    assign udpdata_tready_out  = r_tready;
    assign udp_axis_tdata_out  = w_tdata;
    assign udp_axis_tvalid_out = w_tvalid;
    assign udp_axis_tlast_out  = w_tvalid && w_last_byte;
    assign udp_length_out      = r_length;
    assign busy_out            = (r_state != ST_IDLE);
    assign drop_out            = r_drop;

    // Port fields are plain data captured with the first payload byte.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && w_in_hs) begin
            r_src <= src_port_in;
            r_dst <= dest_port_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_hdr_idx <= 3'd0;
            r_count   <= '0;
            r_length  <= 16'h0000;
            r_tready  <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_in_hs) begin
                        r_count <= w_count_inc;
                        if (udpdata_tlast_in) begin
                            r_length  <= w_len_next;
                            r_hdr_idx <= 3'd0;
                            r_tready  <= 1'b0;
                            r_state   <= ST_HDR;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_in_hs) begin
                        if (w_buf_full) begin
                            r_drop  <= 1'b1;
                            r_count <= '0;
                            r_state <= udpdata_tlast_in ? ST_IDLE : ST_DROP;
                        end else begin
                            r_count <= w_count_inc;
                            if (udpdata_tlast_in) begin
                                r_length  <= w_len_next;
                                r_hdr_idx <= 3'd0;
                                r_tready  <= 1'b0;
                                r_state   <= ST_HDR;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (w_in_hs && udpdata_tlast_in) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (w_out_hs) begin
                        r_hdr_idx <= r_hdr_idx + 3'd1;
                        if (r_hdr_idx == HDR_CSUM_LO) begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_out_hs) begin
                        if (w_last_byte) begin
                            r_count  <= '0;
                            r_tready <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_count <= r_count - CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_tready <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_xmit.sv
// Randomized bench for udp_xmit (BUF_AW = 4) with a frame-level reference model
// and a per-cycle output checker.
module tb_udp_xmit;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic        first;
        logic [15:0] len;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  udpdata_tdata_in;
    logic        udpdata_tvalid_in;
    logic        udpdata_tlast_in;
    logic        udpdata_tready_out;
    logic [15:0] src_port_in;
    logic [15:0] dest_port_in;
    logic [7:0]  udp_axis_tdata_out;
    logic        udp_axis_tvalid_out;
    logic        udp_axis_tlast_out;
    logic        udp_axis_tready_in;
    logic [15:0] udp_length_out;
    logic        busy_out;
    logic        drop_out;

    always #5 clk = ~clk;

    udp_xmit #(.BUF_AW(AW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .udpdata_tdata_in    (udpdata_tdata_in),
        .udpdata_tvalid_in   (udpdata_tvalid_in),
        .udpdata_tlast_in    (udpdata_tlast_in),
        .udpdata_tready_out  (udpdata_tready_out),
        .src_port_in         (src_port_in),
        .dest_port_in        (dest_port_in),
        .udp_axis_tdata_out  (udp_axis_tdata_out),
        .udp_axis_tvalid_out (udp_axis_tvalid_out),
        .udp_axis_tlast_out  (udp_axis_tlast_out),
        .udp_axis_tready_in  (udp_axis_tready_in),
        .udp_length_out      (udp_length_out),
        .busy_out            (busy_out),
        .drop_out            (drop_out)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          out_cnt = 0;
    ent_t        exp_q[$];
    ent_t        mdl[$];
    ent_t        mon_e;
    logic [7:0]  pl[$];
    logic [7:0]  cap[$];
    logic        capl[$];
    logic [15:0] first_len = 16'h0;
    bit          mon_en = 1'b1;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_d = 8'h0;
    logic        prev_l = 1'b0;
    int          rmode = 0;
    logic [1:0]  ph = 2'd0;
    logic [3:0]  tog = 4'b1001;
    logic [7:0]  lit1 [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: a frame of n bytes either becomes header+payload or is dropped.
    task automatic model_frame(input logic [15:0] s, input logic [15:0] d);
        int          n;
        logic [15:0] len;
        logic [63:0] hdr;
        ent_t        e;
        n = pl.size();
        mdl.delete();
        if (n > DEPTH) return;
        len = 16'(n + 8);
        hdr = {s, d, len, 16'h0000};
        for (int k = 0; k < 8; k++) begin
            e.d = 8'(hdr >> (56 - 8 * k));
            e.l = 1'b0;
            e.first = (k == 0);
            e.len = len;
            mdl.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            e.d = pl[k];
            e.l = (k == n - 1);
            e.first = 1'b0;
            e.len = len;
            mdl.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [15:0] s, input logic [15:0] d, input int gap_pct);
        int n;
        bit hs;
        int guard;
        n = pl.size();
        model_frame(s, d);
        foreach (mdl[k]) exp_q.push_back(mdl[k]);
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                udpdata_tvalid_in = 1'b0;
                @(posedge clk); #1;
            end
            udpdata_tdata_in  = pl[i];
            udpdata_tvalid_in = 1'b1;
            udpdata_tlast_in  = (i == n - 1);
            src_port_in  = (i == 0) ? s : 16'($urandom);
            dest_port_in = (i == 0) ? d : 16'($urandom);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 3000) begin
                @(negedge clk);
                hs = udpdata_tready_out;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) begin
                chk("in_hs_timeout", 32'(hs), 32'(1));
                udpdata_tvalid_in = 1'b0;
                udpdata_tlast_in  = 1'b0;
                return;
            end
            chk("drop_pulse", 32'(drop_out), 32'(n > DEPTH && i == DEPTH));
            if (i == 0) chk("busy_fill", 32'(busy_out), 32'(1));
        end
        udpdata_tvalid_in = 1'b0;
        udpdata_tlast_in  = 1'b0;
        chk("hdr_latency", 32'(udp_axis_tvalid_out), 32'(n <= DEPTH));
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy_out) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(done), 32'(1));
    endtask

    task automatic check_lit1();
        chk("lit_count", 32'(cap.size()), 32'(12));
        for (int k = 0; k < 12 && k < cap.size(); k++) begin
            chk("lit_byte", 32'(cap[k]), 32'(lit1[k]));
            chk("lit_last", 32'(capl[k]), 32'(k == 11));
        end
    endtask

    always begin
        @(posedge clk); #1;
        case (rmode)
            1: udp_axis_tready_in = 1'($urandom_range(1));
            2: begin
                udp_axis_tready_in = tog[ph];
                ph = ph + 2'd1;
            end
            default: udp_axis_tready_in = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(udp_axis_tvalid_out), 32'(1));
                chk("hold_data", 32'(udp_axis_tdata_out), 32'(prev_d));
                chk("hold_last", 32'(udp_axis_tlast_out), 32'(prev_l));
            end
            if (udp_axis_tvalid_out) chk("tready_out_while_tx", 32'(udpdata_tready_out), 32'(0));
            else chk("tlast_without_valid", 32'(udp_axis_tlast_out), 32'(0));
            if (udp_axis_tvalid_out && udp_axis_tready_in) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got byte %0h expected no output at %0t",
                             udp_axis_tdata_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", 32'(udp_axis_tdata_out), 32'(mon_e.d));
                    chk("out_last", 32'(udp_axis_tlast_out), 32'(mon_e.l));
                    if (mon_e.first) begin
                        chk("udp_length", 32'(udp_length_out), 32'(mon_e.len));
                        first_len = udp_length_out;
                    end
                end
                cap.push_back(udp_axis_tdata_out);
                capl.push_back(udp_axis_tlast_out);
                out_cnt++;
            end
            prev_stall = udp_axis_tvalid_out && !udp_axis_tready_in;
            prev_d = udp_axis_tdata_out;
            prev_l = udp_axis_tlast_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bit got;
        int n;
        lit1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0C, 8'h00, 8'h00,
                 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        reset_n = 1'b0;
        udpdata_tdata_in = 8'h00;
        udpdata_tvalid_in = 1'b0;
        udpdata_tlast_in = 1'b0;
        src_port_in = 16'h0;
        dest_port_in = 16'h0;
        udp_axis_tready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(udpdata_tready_out), 32'(0));
        chk("rst_tvalid", 32'(udp_axis_tvalid_out), 32'(0));
        chk("rst_tlast", 32'(udp_axis_tlast_out), 32'(0));
        chk("rst_tdata", 32'(udp_axis_tdata_out), 32'(0));
        chk("rst_busy", 32'(busy_out), 32'(0));
        chk("rst_drop", 32'(drop_out), 32'(0));
        chk("rst_length", 32'(udp_length_out), 32'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_rst", 32'(udpdata_tready_out), 32'(1));

        // Model pinned against the hand-built scenario-1 datagram.
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model_frame(16'h1234, 16'h5678);
        chk("model_size", 32'(mdl.size()), 32'(12));
        for (int k = 0; k < 12 && k < mdl.size(); k++)
            chk("model_byte", 32'(mdl[k].d), 32'(lit1[k]));
        chk("model_len", 32'(mdl[0].len), 32'(16'h000C));

        rmode = 0;
        cap.delete(); capl.delete();
        send_frame(16'h1234, 16'h5678, 0);
        wait_idle();
        check_lit1();
        chk("len_4", 32'(first_len), 32'(16'h000C));

        pl = '{8'h55};
        cap.delete(); capl.delete();
        send_frame(16'hAB01, 16'h0203, 0);
        chk("one_byte_hdr0", 32'(udp_axis_tdata_out), 32'(8'hAB));
        wait_idle();
        chk("one_byte_count", 32'(cap.size()), 32'(9));
        chk("one_byte_len", 32'(first_len), 32'(16'h0009));

        rmode = 2;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cap.delete(); capl.delete();
        send_frame(16'h1234, 16'h5678, 0);
        wait_idle();
        check_lit1();

        rmode = 1;
        pl.delete();
        for (int k = 0; k < 16; k++) pl.push_back(8'($urandom));
        cap.delete(); capl.delete();
        send_frame(16'h1111, 16'h2222, 20);
        wait_idle();
        chk("full_count", 32'(cap.size()), 32'(24));
        chk("full_len", 32'(first_len), 32'(16'h0018));

        pl.delete();
        for (int k = 0; k < 20; k++) pl.push_back(8'($urandom));
        cap.delete(); capl.delete();
        send_frame(16'h3333, 16'h4444, 0);
        wait_idle();
        chk("drop_nothing_out", 32'(cap.size()), 32'(0));
        pl = '{8'hA5, 8'h5A};
        send_frame(16'h5555, 16'h6666, 0);
        wait_idle();
        chk("after_drop_count", 32'(cap.size()), 32'(10));
        chk("after_drop_len", 32'(first_len), 32'(16'h000A));

        rmode = 0;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        base = out_cnt;
        send_frame(16'h7777, 16'h8888, 0);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (out_cnt >= base + 11) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_wait", 32'(got), 32'(1));
        mon_en = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_tvalid", 32'(udp_axis_tvalid_out), 32'(0));
        chk("midrst_tlast", 32'(udp_axis_tlast_out), 32'(0));
        chk("midrst_tdata", 32'(udp_axis_tdata_out), 32'(0));
        chk("midrst_busy", 32'(busy_out), 32'(0));
        chk("midrst_tready", 32'(udpdata_tready_out), 32'(0));
        exp_q.delete();
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tready_back", 32'(udpdata_tready_out), 32'(1));
        mon_en = 1'b1;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cap.delete(); capl.delete();
        send_frame(16'h1234, 16'h5678, 0);
        wait_idle();
        check_lit1();

        rmode = 1;
        cap.delete(); capl.delete();
        pl = '{8'h10, 8'h20, 8'h30};
        send_frame(16'h0A0B, 16'h0C0D, 0);
        pl = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        send_frame(16'h0E0F, 16'h1011, 0);
        wait_idle();
        chk("b2b_count", 32'(cap.size()), 32'(11 + 13));

        for (int f = 0; f < 40; f++) begin
            rmode = int'($urandom_range(2));
            n = int'($urandom_range(20, 1));
            pl.delete();
            repeat (n) pl.push_back(8'($urandom));
            send_frame(16'($urandom), 16'($urandom), int'($urandom_range(40)));
            if ($urandom_range(3) == 0) wait_idle();
        end
        rmode = 0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
